code_game_ctrl: RTL and testbench
=================================

// Module: code_game_ctrl
// PURPOSE
//  Game sequencer for the 4-peg secret-code game. Samples the free-running prng
//  outputs (code0..code3) to fix a secret on new_game, accepts packed 4-peg guesses,
//  scores each (exact/partial) via a multi-cycle per-colour pass, counts turns and
//  declares win/lose. Sits between the prng and the input/display logic.
// PARAMETERS
//  MAX_TURNS  10  guesses allowed per game; legal range 1..15 (turn is 4 bits)
//  COLOR_W    3   bits per peg; NUM_COLORS = 2**COLOR_W (fixed 8 for this game)
// PORTS
//  clk          in   1   system clock, all logic rising-edge
//  rst          in   1   synchronous, active-high reset
//  new_game     in   1   1-cycle pulse: start/restart a game
//  code0..code3 in   3   prng pegs 0..3, sampled only on new_game
//  guess_valid  in   1   1-cycle pulse: guess_in is valid
//  guess_in     in   12  packed guess; [2:0]=peg0 .. [11:9]=peg3
//  ready        out  1   high only in WAIT_GUESS
//  score_valid  out  1   1-cycle pulse; exact/partial updated this cycle
//  exact        out  3   right colour, right peg (0..4)
//  partial      out  3   right colour, wrong peg (0..4)
//  turn         out  4   guesses scored this game
//  win          out  1   level, held until new_game/rst
//  lose         out  1   level, held until new_game/rst
//  secret_out   out  12  secret, same packing as guess_in; zero unless win|lose
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; secret, guess and accumulators cleared.
//  States: IDLE, WAIT_GUESS, SCORE, RESULT, WON, LOST.
//  new_game (any state except during rst): secret<={code3,code2,code1,code0} on that
//   edge; turn,exact,partial,win,lose<=0; -> WAIT_GUESS. Beats guess_valid in the
//   same cycle; aborts an in-flight SCORE with no score_valid.
//  guess_valid honoured only in WAIT_GUESS; ignored elsewhere (no queueing).
//   Cycle t: latch guess, exact_acc<=count(secret[i]==guess[i]), c<=0, -> SCORE.
//  SCORE: cycles t+1..t+8, one colour c per cycle:
//   acc += min(#secret pegs==c, #guess pegs==c); c wraps 7->0 on exit -> RESULT.
//  RESULT (cycle t+9): score_valid=1, exact<=exact_acc, partial<=acc-exact_acc,
//   turn<=turn+1. Next: exact_acc==4 -> WON (win=1); else turn+1==MAX_TURNS -> LOST
//   (lose=1); else -> WAIT_GUESS. Win takes priority over lose on the last turn.
//  Latency guess_valid -> score_valid: exactly 9 cycles; ready low from t+1 until
//   WAIT_GUESS re-entered at t+10.
//  exact/partial hold last score until next RESULT, new_game or rst.
//  WON/LOST: terminal, secret_out driven, only new_game or rst leaves.
//  rst wins over every input; mid-SCORE rst -> IDLE next edge, all outputs 0.
//  Widths: acc 3 bits (max 4); partial = acc-exact never negative by construction.
// STRUCTURE
//  Package code_game_pkg: state enum, PEGS=4, COLOR_W, NUM_COLORS, peg pack/unpack
//   helper function.
//  Sub-module guess_scorer: holds secret/guess copies, colour counter c, exact_acc and
//   acc; start/done handshake with the FSM here. FSM, turn, win/lose in top.
// TESTING
//  1 rst; new_game with code0..3=5,1,1,3; guess_in=12'o3115 -> score_valid 9 cycles
//    after guess_valid, exact=4 partial=0 win=1 turn=1 secret_out=12'o3115.
//  2 secret pegs0..3=1,1,2,3; guess pegs 1,2,1,1 -> exact=1 partial=2, ready back at t+10.
//  3 MAX_TURNS=3, three wrong guesses -> third RESULT sets lose=1 turn=3, secret_out
//    shown; 4th guess_valid ignored (no score_valid).
//  4 guess_valid during SCORE ignored; new_game+guess_valid same cycle -> new secret,
//    turn=0, no score_valid within 12 cycles.
//  5 rst at SCORE cycle 4 -> next edge all outputs 0, ready=0; new_game restarts cleanly.
//  6 last-turn exact match with MAX_TURNS=1 -> win=1, lose=0.

Source files
------------

// File: rtl/code_game_pkg.sv
// Shared types, sizes and peg helpers for the 4-peg secret-code game.
package code_game_pkg;

  localparam int PEGS       = 4;
  localparam int COLOR_W    = 3;
  localparam int NUM_COLORS = 2 ** COLOR_W;
  localparam int CODE_W     = PEGS * COLOR_W;
  localparam int CNT_W      = 3;

  typedef logic [COLOR_W-1:0] peg_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [CODE_W-1:0]  code_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GUESS,
    SCORE,
    RESULT,
    WON,
    LOST
  } state_t;

  function automatic peg_t peg_at(input code_t code, input int idx);
    return code[idx*COLOR_W +: COLOR_W];
  endfunction

  function automatic code_t pack_pegs(input peg_t p0, input peg_t p1,
                                      input peg_t p2, input peg_t p3);
    return {p3, p2, p1, p0};
  endfunction

  function automatic cnt_t count_color(input code_t code, input peg_t color);
    cnt_t n;
    n = '0;
    for (int i = 0; i < PEGS; i++)
      if (peg_at(code, i) == color) n = n + cnt_t'(1);
    return n;
  endfunction

  function automatic cnt_t count_exact(input code_t a, input code_t b);
    cnt_t n;
    n = '0;
    for (int i = 0; i < PEGS; i++)
      if (peg_at(a, i) == peg_at(b, i)) n = n + cnt_t'(1);
    return n;
  endfunction

endpackage

// File: rtl/code_game_if.sv
// Game bus: prng pegs and guesses in, score/turn/result out.
interface code_game_if;
  import code_game_pkg::*;

  logic  new_game;
  peg_t  code0, code1, code2, code3;
  logic  guess_valid;
  code_t guess_in;
  logic  ready;
  logic  score_valid;
  cnt_t  exact;
  cnt_t  partial;
  logic [3:0] turn;
  logic  win;
  logic  lose;
  code_t secret_out;

  modport master (
    output new_game, code0, code1, code2, code3, guess_valid, guess_in,
    input  ready, score_valid, exact, partial, turn, win, lose, secret_out
  );

  modport slave (
    input  new_game, code0, code1, code2, code3, guess_valid, guess_in,
    output ready, score_valid, exact, partial, turn, win, lose, secret_out
  );
endinterface

// File: rtl/code_game_guess_scorer.sv
// Holds secret and guess; scores one colour per cycle after a start pulse.
module guess_scorer
  import code_game_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_secret,
  input  code_t secret_in,
  input  logic  abort,
  input  logic  start,
  input  code_t guess_in,
  output logic  done,
  output cnt_t  exact_acc,
  output cnt_t  total,
  output code_t secret
);

  code_t guess;
  peg_t  color;
  cnt_t  acc;
  logic  busy;
  cnt_t  n_secret, n_guess;

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    n_secret = count_color(secret, color);
    n_guess  = count_color(guess, color);
    total    = acc + ((n_secret < n_guess) ? n_secret : n_guess);
    done     = busy && (color == peg_t'(NUM_COLORS - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      secret    <= '0;
      guess     <= '0;
      color     <= '0;
      acc       <= '0;
      exact_acc <= '0;
      busy      <= 1'b0;
    end else begin
      if (load_secret) secret <= secret_in;
      if (abort) begin
        busy  <= 1'b0;
        color <= '0;
      end else if (start) begin
        guess     <= guess_in;
        exact_acc <= count_exact(secret, guess_in);
        acc       <= '0;
        color     <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        acc   <= total;
        color <= color + peg_t'(1);   // wraps 7 -> 0 on the final colour
        if (done) busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/code_game_ctrl.sv
// Game sequencer: secret capture, guess acceptance, turn counting, win/lose.
module code_game_ctrl
  import code_game_pkg::*;
#(
  parameter int MAX_TURNS = 10
) (
  input  logic        clk,
  input  logic        rst,
  code_game_if.slave  bus
);

  state_t     state, state_n;
  logic       start, done;
  cnt_t       exact_acc, total;
  code_t      secret;
  cnt_t       exact_r, partial_r;
  logic [3:0] turn_r;
  logic       win_r, lose_r;

  guess_scorer u_scorer (
    .clk         (clk),
    .rst         (rst),
    .load_secret (bus.new_game),
    .secret_in   (pack_pegs(bus.code0, bus.code1, bus.code2, bus.code3)),
    .abort       (bus.new_game),
    .start       (start),
    .guess_in    (bus.guess_in),
    .done        (done),
    .exact_acc   (exact_acc),
    .total       (total),
    .secret      (secret)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    if (bus.new_game) begin
      state_n = WAIT_GUESS;
    end else begin
      case (state)
        IDLE, WON, LOST: state_n = state;
        WAIT_GUESS: if (bus.guess_valid) begin
          start   = 1'b1;
          state_n = SCORE;
        end
        SCORE:  if (done) state_n = RESULT;
        RESULT: begin
          // a last-turn exact match is a win, never a loss
          if (exact_r == cnt_t'(PEGS))          state_n = WON;
          else if (turn_r == 4'(MAX_TURNS))     state_n = LOST;
          else                                  state_n = WAIT_GUESS;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Scores land on the edge that leaves SCORE so they coincide with score_valid.
  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      exact_r   <= '0;
      partial_r <= '0;
      turn_r    <= '0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
    end else begin
      if (done) begin
        exact_r   <= exact_acc;
        partial_r <= total - exact_acc;
        turn_r    <= turn_r + 4'd1;
      end
      if (state == RESULT) begin
        win_r  <= (exact_r == cnt_t'(PEGS));
        lose_r <= (exact_r != cnt_t'(PEGS)) && (turn_r == 4'(MAX_TURNS));
      end
    end
  end

  assign bus.ready       = (state == WAIT_GUESS);
  assign bus.score_valid = (state == RESULT);
  assign bus.exact       = exact_r;
  assign bus.partial     = partial_r;
  assign bus.turn        = turn_r;
  assign bus.win         = win_r;
  assign bus.lose        = lose_r;
  assign bus.secret_out  = (win_r || lose_r) ? secret : '0;

endmodule

// File: tb/tb_code_game_ctrl.sv
// Scoreboard bench: three controllers (MAX_TURNS 10, 3, 1) share one stimulus stream.
module tb_code_game_ctrl;
  import code_game_pkg::*;

  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        new_game = 1'b0, guess_valid = 1'b0;
  logic [11:0] guess_in = '0, codes = '0;

  code_game_if bus0 (), bus1 (), bus2 ();

  assign bus0.new_game = new_game, bus0.guess_valid = guess_valid, bus0.guess_in = guess_in,
         bus0.code0 = codes[2:0], bus0.code1 = codes[5:3], bus0.code2 = codes[8:6], bus0.code3 = codes[11:9];
  assign bus1.new_game = new_game, bus1.guess_valid = guess_valid, bus1.guess_in = guess_in,
         bus1.code0 = codes[2:0], bus1.code1 = codes[5:3], bus1.code2 = codes[8:6], bus1.code3 = codes[11:9];
  assign bus2.new_game = new_game, bus2.guess_valid = guess_valid, bus2.guess_in = guess_in,
         bus2.code0 = codes[2:0], bus2.code1 = codes[5:3], bus2.code2 = codes[8:6], bus2.code3 = codes[11:9];

  code_game_ctrl #(.MAX_TURNS(10)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  code_game_ctrl #(.MAX_TURNS(3))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  code_game_ctrl #(.MAX_TURNS(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic        rdy[3], sv[3], wn[3], ls[3];
  logic [2:0]  ex[3], pa[3];
  logic [3:0]  tu[3];
  logic [11:0] so[3];
  assign rdy[0] = bus0.ready, sv[0] = bus0.score_valid, wn[0] = bus0.win, ls[0] = bus0.lose,
         ex[0] = bus0.exact, pa[0] = bus0.partial, tu[0] = bus0.turn, so[0] = bus0.secret_out;
  assign rdy[1] = bus1.ready, sv[1] = bus1.score_valid, wn[1] = bus1.win, ls[1] = bus1.lose,
         ex[1] = bus1.exact, pa[1] = bus1.partial, tu[1] = bus1.turn, so[1] = bus1.secret_out;
  assign rdy[2] = bus2.ready, sv[2] = bus2.score_valid, wn[2] = bus2.win, ls[2] = bus2.lose,
         ex[2] = bus2.exact, pa[2] = bus2.partial, tu[2] = bus2.turn, so[2] = bus2.secret_out;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    int inst;
    int at;
    int ex;
    int pa;
    int tu;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          max_t[3] = '{10, 3, 1};
  bit          active[3] = '{0, 0, 0};
  bit          over[3] = '{0, 0, 0};
  int          ready_from[3] = '{0, 0, 0};
  int          win_at[3] = '{BIG, BIG, BIG};
  int          lose_at[3] = '{BIG, BIG, BIG};
  int          turn_m[3] = '{0, 0, 0};
  logic [11:0] sec_p = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ready_exp(input int k, input int y);
    return active[k] && !over[k] && (y >= ready_from[k]);
  endfunction

  // Mastermind scoring: exact matches, then colour-multiset overlap minus exact.
  function automatic void score(input logic [11:0] s, input logic [11:0] g, output int e, output int p);
    int cs[8];
    int cg[8];
    int tot;
    int a, b;
    e = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
    for (int i = 0; i < 4; i++) begin
      a = int'(s[3*i +: 3]);
      b = int'(g[3*i +: 3]);
      if (a == b) e++;
      cs[a]++;
      cg[b]++;
    end
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    p = tot - e;
  endfunction

  task automatic flush(input int x);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].at > x) q.delete(i);
  endtask

  task automatic model_step(input bit r, input bit ng, input bit gv,
                            input logic [11:0] g, input logic [11:0] cp);
    int x;
    int e, p;
    x = cyc;
    if (r) begin
      flush(x);
      for (int k = 0; k < 3; k++) begin
        active[k] = 1'b0; win_at[k] = BIG; lose_at[k] = BIG;
      end
    end else if (ng) begin
      flush(x);
      sec_p = cp;
      for (int k = 0; k < 3; k++) begin
        active[k] = 1'b1; over[k] = 1'b0; turn_m[k] = 0;
        ready_from[k] = x + 1; win_at[k] = BIG; lose_at[k] = BIG;
      end
    end else if (gv) begin
      score(sec_p, g, e, p);
      for (int k = 0; k < 3; k++) begin
        if (ready_exp(k, x)) begin
          turn_m[k]++;
          q.push_back('{inst: k, at: x + 9, ex: e, pa: p, tu: turn_m[k]});
          ready_from[k] = x + 10;
          if (e == 4) begin
            over[k] = 1'b1; win_at[k] = x + 10;
          end else if (turn_m[k] == max_t[k]) begin
            over[k] = 1'b1; lose_at[k] = x + 10;
          end
        end
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        bit          w_e, l_e;
        logic [11:0] so_e;
        int          idx;
        w_e  = (cyc >= win_at[k]);
        l_e  = (cyc >= lose_at[k]);
        so_e = (w_e || l_e) ? sec_p : 12'h000;
        check($sformatf("ready[%0d]", k), rdy[k], ready_exp(k, cyc));
        check($sformatf("win[%0d]", k), wn[k], w_e);
        check($sformatf("lose[%0d]", k), ls[k], l_e);
        check($sformatf("secret_out[%0d]", k), so[k], so_e);
        idx = -1;
        for (int i = 0; i < q.size(); i++)
          if (idx < 0 && q[i].inst == k && q[i].at == cyc) idx = i;
        if (idx >= 0) begin
          check($sformatf("score_valid[%0d]", k), sv[k], 1);
          if (sv[k]) begin
            check($sformatf("exact[%0d]", k), ex[k], q[idx].ex);
            check($sformatf("partial[%0d]", k), pa[k], q[idx].pa);
            check($sformatf("turn[%0d]", k), tu[k], q[idx].tu);
          end
          q.delete(idx);
        end else begin
          check($sformatf("no score_valid[%0d]", k), sv[k], 0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input bit r, input bit ng, input bit gv,
                      input logic [11:0] g, input logic [11:0] cp);
    @(negedge clk);
    rst = r; new_game = ng; guess_valid = gv; guess_in = g; codes = cp;
    model_step(r, ng, gv, g, cp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
  endtask

  task automatic do_new(input logic [11:0] cp);
    tick(1'b0, 1'b1, 1'b0, 12'h000, cp);
  endtask

  task automatic do_guess(input logic [11:0] g);
    tick(1'b0, 1'b0, 1'b1, g, 12'h000);
  endtask

  initial begin
    logic [11:0] g, cp;
    bit r, ng, gv;

    // reset state
    mon_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
    tick(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
    idle(1);
    check("rst exact", bus0.exact, 0);
    check("rst partial", bus0.partial, 0);
    check("rst turn", bus0.turn, 0);
    check("rst ready", bus0.ready, 0);

    // exact hit on first guess; MAX_TURNS=1 instance must win, not lose
    do_new({3'd3, 3'd1, 3'd1, 3'd5});
    do_guess(12'o3115);
    idle(10);
    check("t1 win", bus0.win, 1);
    check("t1 turn", bus0.turn, 1);
    check("t1 exact", bus0.exact, 4);
    check("t1 secret_out", bus0.secret_out, 12'o3115);
    check("t6 win max1", bus2.win, 1);
    check("t6 lose max1", bus2.lose, 0);

    // secret 1,1,2,3 vs guess 1,2,1,1
    do_new({3'd3, 3'd2, 3'd1, 3'd1});
    do_guess(12'o1121);
    idle(10);
    check("t2 exact", bus0.exact, 1);
    check("t2 partial", bus0.partial, 2);
    check("t2 ready", bus0.ready, 1);

    // three misses exhaust MAX_TURNS=3; a fourth guess is ignored there
    do_new({3'd0, 3'd6, 3'd4, 3'd2});
    for (int i = 0; i < 3; i++) begin
      do_guess(12'o7777);
      idle(10);
    end
    check("t3 lose", bus1.lose, 1);
    check("t3 turn", bus1.turn, 3);
    check("t3 secret_out", bus1.secret_out, 12'o0642);
    do_guess(12'o7777);
    idle(11);

    // guess during SCORE ignored; new_game beats a simultaneous guess
    do_new({3'd1, 3'd2, 3'd3, 3'd4});
    do_guess(12'o1111);
    idle(3);
    do_guess(12'o1234);
    idle(10);
    tick(1'b0, 1'b1, 1'b1, 12'o2222, {3'd7, 3'd7, 3'd0, 3'd0});
    idle(12);
    check("t4 turn", bus0.turn, 0);

    // reset in SCORE cycle 4 after a scored guess
    do_new({3'd3, 3'd2, 3'd1, 3'd1});
    do_guess(12'o1121);
    idle(10);
    do_guess(12'o1121);
    idle(3);
    tick(1'b1, 1'b0, 1'b0, 12'h000, 12'h000);
    idle(1);
    check("t5 exact", bus0.exact, 0);
    check("t5 partial", bus0.partial, 0);
    check("t5 turn", bus0.turn, 0);
    check("t5 ready", bus0.ready, 0);
    check("t5 score_valid", bus0.score_valid, 0);
    do_new({3'd5, 3'd4, 3'd3, 3'd2});
    do_guess(12'o2345);
    idle(12);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      ng = ($urandom_range(0, 59) == 0);
      gv = ($urandom_range(0, 2) == 0);
      cp = 12'($urandom);
      if ($urandom_range(0, 4) == 0) g = sec_p;
      else g = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      tick(r, ng, gv, g, cp);
    end
    idle(15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
